y86_execute_stage: RTL and testbench

- Parametrised, pipelined Execute stage for the Y86-64 pipelined processor. It sits between the Decode/Execute and Execute/Memory boundaries.
- Computes valE, evaluates cnd against an internal condition-code (CC) register, and resolves dstE for cmovXX.
- Registers all results into an E/M pipeline register with a valid/ready handshake and a bubble control.
- Provides combinational forwarding outputs for the bypass network.

---
 rtl/y86_execute_stage.sv | 160 ++++++++++++++++
 tb/tb_y86_execute_stage.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_execute_stage.sv
// Y86-64 pipelined Execute stage: ALU, condition codes, cmov resolution and the E/M register.
// Define EXEC_EXC_GUARD_EN to suppress CC updates while an exception is in flight.
module y86_execute_stage #(
  parameter int unsigned N          = 64,
  parameter int unsigned STACK_STEP = 8,
  parameter int unsigned REG_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_icode,
  input  logic [3:0]       in_ifun,
  input  logic [1:0]       in_stat,
  input  logic [N-1:0]     in_valA,
  input  logic [N-1:0]     in_valB,
  input  logic [N-1:0]     in_valC,
  input  logic [REG_W-1:0] in_dstE,
  input  logic [REG_W-1:0] in_dstM,
  input  logic             mw_exc,
  input  logic             bubble,
  input  logic             out_ready,
  output logic             m_valid,
  output logic [3:0]       m_icode,
  output logic [1:0]       m_stat,
  output logic             m_cnd,
  output logic [N-1:0]     m_valE,
  output logic [N-1:0]     m_valA,
  output logic [REG_W-1:0] m_dstE,
  output logic [REG_W-1:0] m_dstM,
  output logic [N-1:0]     e_valE,
  output logic [REG_W-1:0] e_dstE,
  output logic [2:0]       cc_out
);

  localparam logic [3:0] INop   = 4'd1;
  localparam logic [3:0] ICmov  = 4'd2;
  localparam logic [3:0] IIrmov = 4'd3;
  localparam logic [3:0] IRmmov = 4'd4;
  localparam logic [3:0] IMrmov = 4'd5;
  localparam logic [3:0] IOpq   = 4'd6;
  localparam logic [3:0] IJxx   = 4'd7;
  localparam logic [3:0] ICall  = 4'd8;
  localparam logic [3:0] IRet   = 4'd9;
  localparam logic [3:0] IPush  = 4'd10;
  localparam logic [3:0] IPop   = 4'd11;

  localparam logic [N-1:0] Step = N'(STACK_STEP);

  logic [2:0] cc_q;  // {ZF, SF, OF}
  logic       alu_of;
  logic       cond_met;
  logic       cnd;
  logic       accept;
  logic       cc_guard;
  logic       cc_we;

  always_comb begin
    e_valE = '0;
    case (in_icode)
      IOpq: begin
        case (in_ifun)
          4'd0:    e_valE = in_valB + in_valA;
          4'd1:    e_valE = in_valB - in_valA;
          4'd2:    e_valE = in_valB & in_valA;
          4'd3:    e_valE = in_valB ^ in_valA;
          default: e_valE = '0;
        endcase
      end
      IIrmov:         e_valE = in_valC;
      IRmmov, IMrmov: e_valE = in_valB + in_valC;
      ICmov:          e_valE = in_valA;
      ICall, IPush:   e_valE = in_valB - Step;
      IRet, IPop:     e_valE = in_valB + Step;
      default:        e_valE = '0;
    endcase
  end

  always_comb begin
    alu_of = 1'b0;
    if (in_icode == IOpq) begin
      case (in_ifun)
        4'd0:    alu_of = (in_valA[N-1] == in_valB[N-1]) && (e_valE[N-1] != in_valB[N-1]);
        4'd1:    alu_of = (in_valA[N-1] != in_valB[N-1]) && (e_valE[N-1] != in_valB[N-1]);
        default: alu_of = 1'b0;
      endcase
    end
  end

  // Conditions use the CC as it stands before this instruction's own update.
  always_comb begin
    case (in_ifun)
      4'd0:    cond_met = 1'b1;
      4'd1:    cond_met = (cc_q[1] ^ cc_q[0]) | cc_q[2];
      4'd2:    cond_met = cc_q[1] ^ cc_q[0];
      4'd3:    cond_met = cc_q[2];
      4'd4:    cond_met = !cc_q[2];
      4'd5:    cond_met = !(cc_q[1] ^ cc_q[0]);
      4'd6:    cond_met = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
      default: cond_met = 1'b0;
    endcase
  end

  assign cnd    = cond_met && ((in_icode == ICmov) || (in_icode == IJxx));
  assign e_dstE = ((in_icode == ICmov) && !cnd) ? '1 : in_dstE;

  assign in_ready = !bubble && (!m_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign cc_out   = cc_q;

`ifdef EXEC_EXC_GUARD_EN
  assign cc_guard = (in_stat == 2'd0) && !mw_exc;
`else
  logic unused_mw_exc;
  assign unused_mw_exc = mw_exc;
  assign cc_guard      = 1'b1;
`endif

  assign cc_we = accept && (in_icode == IOpq) && cc_guard;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_icode <= INop;
      m_stat  <= 2'd0;
      m_cnd   <= 1'b0;
      m_valE  <= '0;
      m_valA  <= '0;
      m_dstE  <= '1;
      m_dstM  <= '1;
      cc_q    <= 3'b100;
    end else begin
      if (bubble) begin
        m_valid <= 1'b0;
        m_icode <= INop;
        m_stat  <= 2'd0;
        m_cnd   <= 1'b0;
        m_valE  <= '0;
        m_valA  <= '0;
        m_dstE  <= '1;
        m_dstM  <= '1;
      end else if (accept) begin
        m_valid <= 1'b1;
        m_icode <= in_icode;
        m_stat  <= in_stat;
        m_cnd   <= cnd;
        m_valE  <= e_valE;
        m_valA  <= in_valA;
        m_dstE  <= e_dstE;
        m_dstM  <= in_dstM;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
      if (cc_we) begin
        cc_q <= {(e_valE == '0), e_valE[N-1], alu_of};
      end
    end
  end

endmodule

// File: tb/tb_y86_execute_stage.sv
// Bench for y86_execute_stage: directed vector table, stall/bubble/reset sequences, and a
// randomized run against an arithmetic reference model.
module tb_y86_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_icode;
  logic [3:0]  in_ifun;
  logic [1:0]  in_stat;
  logic [63:0] in_valA;
  logic [63:0] in_valB;
  logic [63:0] in_valC;
  logic [3:0]  in_dstE;
  logic [3:0]  in_dstM;
  logic        mw_exc;
  logic        bubble;
  logic        out_ready;
  logic        m_valid;
  logic [3:0]  m_icode;
  logic [1:0]  m_stat;
  logic        m_cnd;
  logic [63:0] m_valE;
  logic [63:0] m_valA;
  logic [3:0]  m_dstE;
  logic [3:0]  m_dstM;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic [2:0]  cc_out;

  always #5 clk = ~clk;

  y86_execute_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_icode  (in_icode),
    .in_ifun   (in_ifun),
    .in_stat   (in_stat),
    .in_valA   (in_valA),
    .in_valB   (in_valB),
    .in_valC   (in_valC),
    .in_dstE   (in_dstE),
    .in_dstM   (in_dstM),
    .mw_exc    (mw_exc),
    .bubble    (bubble),
    .out_ready (out_ready),
    .m_valid   (m_valid),
    .m_icode   (m_icode),
    .m_stat    (m_stat),
    .m_cnd     (m_cnd),
    .m_valE    (m_valE),
    .m_valA    (m_valA),
    .m_dstE    (m_dstE),
    .m_dstM    (m_dstM),
    .e_valE    (e_valE),
    .e_dstE    (e_dstE),
    .cc_out    (cc_out)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [3:0] dste,
                       input logic valid, input logic ordy);
    in_icode  = icode;
    in_ifun   = ifun;
    in_valA   = a;
    in_valB   = b;
    in_valC   = c;
    in_dstE   = dste;
    in_dstM   = 4'hF;
    in_stat   = 2'd0;
    in_valid  = valid;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    bubble = 1'b0;
    mw_exc = 1'b0;
    drive(4'h1, 4'h0, '0, '0, '0, 4'hF, 1'b0, 1'b1);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference model: Y86 semantics in plain arithmetic.
  function automatic logic [63:0] ref_vale(input logic [3:0] ic, input logic [3:0] fn,
                                           input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] c);
    case (ic)
      4'd6:        return (fn == 0) ? b + a : (fn == 1) ? b - a :
                          (fn == 2) ? (b & a) : (fn == 3) ? (b ^ a) : 64'd0;
      4'd3:        return c;
      4'd4, 4'd5:  return b + c;
      4'd2:        return a;
      4'd8, 4'd10: return b - 64'd8;
      4'd9, 4'd11: return b + 64'd8;
      default:     return 64'd0;
    endcase
  endfunction

  // Signed overflow: the 65-bit exact result does not fit in 64 bits.
  function automatic logic ref_of(input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b);
    logic signed [64:0] s;
    if (fn == 0) s = $signed({b[63], b}) + $signed({a[63], a});
    else if (fn == 1) s = $signed({b[63], b}) - $signed({a[63], a});
    else return 1'b0;
    return s[64] ^ s[63];
  endfunction

  function automatic logic ref_cnd(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] cc);
    logic zf, lt;
    if (ic != 4'd2 && ic != 4'd7) return 1'b0;
    zf = cc[2];
    lt = cc[1] ^ cc[0];
    case (fn)
      4'd0: return 1'b1;
      4'd1: return lt || zf;
      4'd2: return lt;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !lt;
      4'd6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'h8000_0000_0000_0000;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [3:0]  dste;
    logic [63:0] x_vale;
    logic        x_cnd;
    logic [3:0]  x_dste;
    logic [2:0]  x_cc;
  } vec_t;

  vec_t vecs[8];

  // Model state for the randomized run.
  logic        r_valid;
  logic [3:0]  r_icode;
  logic [1:0]  r_stat;
  logic        r_cnd;
  logic [63:0] r_vale;
  logic [63:0] r_vala;
  logic [3:0]  r_dste;
  logic [3:0]  r_dstm;
  logic [2:0]  r_cc;

  initial begin
    logic        x_rdy, x_cn, guard;
    logic [63:0] x_v;
    logic [3:0]  x_d;

    vecs[0] = '{4'h6, 4'h1, 64'd7, 64'd5, 64'd0, 4'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4'd2, 3'b010};
    vecs[1] = '{4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'd4,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4'd4, 3'b011};
    // SF=1, OF=1: le and l are false, ge is true.
    vecs[2] = '{4'h2, 4'h1, 64'h55, 64'd0, 64'd0, 4'd3, 64'h55, 1'b0, 4'hF, 3'b011};
    vecs[3] = '{4'h2, 4'h2, 64'h66, 64'd0, 64'd0, 4'd3, 64'h66, 1'b0, 4'hF, 3'b011};
    vecs[4] = '{4'h2, 4'h5, 64'h77, 64'd0, 64'd0, 4'd3, 64'h77, 1'b1, 4'd3, 3'b011};
    vecs[5] = '{4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'd4, 64'hF8, 1'b0, 4'd4, 3'b011};
    vecs[6] = '{4'hB, 4'h0, 64'd0, 64'hF8, 64'd0, 4'd4, 64'h100, 1'b0, 4'd4, 3'b011};
    vecs[7] = '{4'h7, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 64'd0, 1'b1, 4'hF, 3'b011};

    do_reset();
    chk("reset m_valid/icode/dstE/dstM", {m_valid, m_icode, m_dstE, m_dstM}, {1'b0, 4'h1, 4'hF, 4'hF});
    chk("reset valE/valA/cnd/stat", {m_valE, m_valA, m_cnd, m_stat}, {64'd0, 64'd0, 1'b0, 2'd0});
    chk("reset cc", cc_out, 3'b100);

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].icode, vecs[i].ifun, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].dste, 1'b1, 1'b1);
      #1;
      chk($sformatf("vec%0d e_valE/e_dstE", i), {e_valE, e_dstE}, {vecs[i].x_vale, vecs[i].x_dste});
      tick();
      chk($sformatf("vec%0d em", i), {m_valid, m_icode, m_valE, m_cnd, m_dstE},
          {1'b1, vecs[i].icode, vecs[i].x_vale, vecs[i].x_cnd, vecs[i].x_dste});
      chk($sformatf("vec%0d cc", i), cc_out, vecs[i].x_cc);
    end

    // Stall: output blocked for three cycles with a new instruction waiting.
    drive(4'h3, 4'h0, 64'd0, 64'd0, 64'hAAAA, 4'd1, 1'b1, 1'b1);
    tick();
    drive(4'h3, 4'h0, 64'd0, 64'd0, 64'hBBBB, 4'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d in_ready", i), in_ready, 1'b0);
      tick();
      chk($sformatf("stall%0d em hold", i), {m_valid, m_valE, m_dstE}, {1'b1, 64'hAAAA, 4'd1});
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", in_ready, 1'b1);
    tick();
    chk("release load", {m_valid, m_valE, m_dstE}, {1'b1, 64'hBBBB, 4'd2});

    // Bubble squashes the register and blocks the input; CC untouched.
    drive(4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 4'd5, 1'b1, 1'b1);
    bubble = 1'b1;
    #1;
    chk("bubble in_ready", in_ready, 1'b0);
    tick();
    bubble = 1'b0;
    chk("bubble em", {m_valid, m_icode, m_stat, m_cnd, m_valE, m_valA, m_dstE, m_dstM},
        {1'b0, 4'h1, 2'd0, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF});
    chk("bubble cc", cc_out, 3'b011);

    // Exception guard: 1+1 clears CC, then 0+0 with a downstream exception.
    drive(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'd5, 1'b1, 1'b1);
    tick();
    chk("cc after 1+1", cc_out, 3'b000);
    drive(4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 4'd5, 1'b1, 1'b1);
    mw_exc = 1'b1;
    tick();
    mw_exc = 1'b0;
`ifdef EXEC_EXC_GUARD_EN
    chk("guarded cc", cc_out, 3'b000);
`else
    chk("unguarded cc", cc_out, 3'b100);
`endif

    // Reset while stalled drops the pending output and clears CC.
    drive(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'd5, 1'b1, 1'b1);
    tick();
    drive(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 4'd6, 1'b1, 1'b0);
    tick();
    reset  = 1'b1;
    bubble = 1'b1;
    tick();
    reset  = 1'b0;
    bubble = 1'b0;
    chk("reset mid-stall em", {m_valid, m_icode, m_valE, m_dstE}, {1'b0, 4'h1, 64'd0, 4'hF});
    chk("reset mid-stall cc", cc_out, 3'b100);

    // Randomized run against the model.
    do_reset();
    r_valid = 1'b0; r_icode = 4'h1; r_stat = 2'd0; r_cnd = 1'b0;
    r_vale = '0; r_vala = '0; r_dste = 4'hF; r_dstm = 4'hF; r_cc = 3'b100;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_icode  = 4'($urandom_range(0, 11));
      in_ifun   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      in_valA   = rnd64();
      in_valB   = rnd64();
      in_valC   = rnd64();
      in_dstE   = 4'($urandom_range(0, 15));
      in_dstM   = 4'($urandom_range(0, 15));
      in_stat   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      mw_exc    = ($urandom_range(0, 7) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      bubble    = ($urandom_range(0, 9) == 0);
      #1;
      x_rdy = !bubble && (!r_valid || out_ready);
      x_v   = ref_vale(in_icode, in_ifun, in_valA, in_valB, in_valC);
      x_cn  = ref_cnd(in_icode, in_ifun, r_cc);
      x_d   = (in_icode == 4'd2 && !x_cn) ? 4'hF : in_dstE;
      chk($sformatf("rnd%0d comb", cyc), {in_ready, e_valE, e_dstE}, {x_rdy, x_v, x_d});
`ifdef EXEC_EXC_GUARD_EN
      guard = (in_stat == 2'd0) && !mw_exc;
`else
      guard = 1'b1;
`endif
      if (in_valid && x_rdy && in_icode == 4'd6 && guard)
        r_cc = {x_v == 64'd0, x_v[63], ref_of(in_ifun, in_valA, in_valB)};
      if (bubble) begin
        r_valid = 1'b0; r_icode = 4'h1; r_stat = 2'd0; r_cnd = 1'b0;
        r_vale = '0; r_vala = '0; r_dste = 4'hF; r_dstm = 4'hF;
      end else if (in_valid && x_rdy) begin
        r_valid = 1'b1; r_icode = in_icode; r_stat = in_stat; r_cnd = x_cn;
        r_vale = x_v; r_vala = in_valA; r_dste = x_d; r_dstm = in_dstM;
      end else if (out_ready) begin
        r_valid = 1'b0;
      end
      tick();
      chk($sformatf("rnd%0d em", cyc),
          {m_valid, m_icode, m_stat, m_cnd, m_valE, m_valA, m_dstE, m_dstM, cc_out},
          {r_valid, r_icode, r_stat, r_cnd, r_vale, r_vala, r_dste, r_dstm, r_cc});
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
